// File: rtl/aes_pkg.sv
// Shared AES definitions: key-schedule sizes, FSM state encoding, and the
// byte/word helpers used by the key expansion datapath.
package aes_pkg;

    localparam int AES_NK     = 4;
    localparam int AES_NR     = 10;
    localparam int AES_RK_NUM = AES_NR + 1;
    localparam int AES_NW     = AES_NK * AES_RK_NUM;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SUB_REQ,
        SUB_WAIT,
        WORDS,
        FIN
    } ks_state_e;

    // Multiply by x in GF(2^8) modulo the AES polynomial.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] rot_word(input logic [31:0] w);
        return {w[23:0], w[31:24]};
    endfunction

endpackage

// File: rtl/subword.sv
// AES SubWord unit: S-box substitution of all four bytes of a word.
// A one-cycle req captures in_word; ack and out_word follow on the next cycle.
module subword (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req,
    input  logic [31:0] in_word,
    output logic        ack,
    output logic [31:0] out_word
);

    // Forward S-box, byte 0x00 in the most significant position.
    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        logic [2047:0] sh;
        sh = SBOX << {b, 3'b000};
        return sh[2047:2040];
    endfunction

    logic        ack_q;
    logic [31:0] out_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ack_q <= 1'b0;
            out_q <= '0;
        end else begin
            ack_q <= req;
            if (req) begin
                out_q <= {sbox(in_word[31:24]), sbox(in_word[23:16]),
                          sbox(in_word[15:8]),  sbox(in_word[7:0])};
            end
        end
    end

    assign ack      = ack_q;
    assign out_word = out_q;

endmodule

// File: rtl/key_expansion_128.sv
// AES-128 key schedule: expands key_in into 44 words and serves round keys via a registered port.
// Optional macro KEYEXP_ZEROIZE_EN adds a zeroize input that wipes the store and aborts expansion.
module key_expansion_128
    import aes_pkg::*;
#(
    parameter int KEY_W      = 128,
    parameter int NUM_ROUNDS = AES_NR
) (
    input  logic             clk,
    input  logic             rst_n,
`ifdef KEYEXP_ZEROIZE_EN
    input  logic             zeroize,
`endif
    input  logic             start,
    input  logic [KEY_W-1:0] key_in,
    output logic             busy,
    output logic             done,
    output logic             key_valid,
    input  logic [3:0]       rk_idx,
    output logic [KEY_W-1:0] rk_out
);

    localparam int         NUM_WORDS  = AES_NK * (NUM_ROUNDS + 1);
    localparam logic [3:0] LAST_ROUND = 4'(NUM_ROUNDS);
    localparam logic [5:0] NW6        = 6'(NUM_WORDS);

    logic zeroize_c;
`ifdef KEYEXP_ZEROIZE_EN
    assign zeroize_c = zeroize;
`else
    assign zeroize_c = 1'b0;
`endif

    ks_state_e        state_q, state_d;
    logic [3:0]       round_q, round_d;
    logic [7:0]       rcon_q,  rcon_d;
    logic [1:0]       j_q,     j_d;
    logic             kv_q,    kv_d;
    logic [KEY_W-1:0] key_q;
    logic [31:0]      store_q [NUM_WORDS];
    logic [KEY_W-1:0] rk_q,    rk_d;

    logic        accept_c, load_c, wr_en_c;
    logic [5:0]  wr_addr_c, back1_addr_c, back4_addr_c, rk_addr_c;
    logic [31:0] wr_data_c, back1_word_c, back4_word_c;
    logic        sub_req, sub_ack;
    logic [31:0] sub_in, sub_out;

    // j is 0 in SUB_REQ/SUB_WAIT, so one address set serves every step of a round.
    assign wr_addr_c    = {round_q, 2'b00} + {4'b0000, j_q};
    assign back1_addr_c = wr_addr_c - 6'd1;
    assign back4_addr_c = wr_addr_c - 6'd4;
    assign back1_word_c = (back1_addr_c < NW6) ? store_q[back1_addr_c] : '0;
    assign back4_word_c = (back4_addr_c < NW6) ? store_q[back4_addr_c] : '0;

    assign sub_req = (state_q == SUB_REQ);
    assign sub_in  = rot_word(back1_word_c);

    subword u_subword (
        .clk      (clk),
        .rst_n    (rst_n),
        .req      (sub_req),
        .in_word  (sub_in),
        .ack      (sub_ack),
        .out_word (sub_out)
    );

    // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latches).
    always_comb begin
        state_d   = state_q;
        round_d   = round_q;
        rcon_d    = rcon_q;
        j_d       = j_q;
        kv_d      = kv_q;
        accept_c  = 1'b0;
        load_c    = 1'b0;
        wr_en_c   = 1'b0;
        wr_data_c = '0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    accept_c = 1'b1;
                    kv_d     = 1'b0;
                    state_d  = LOAD;
                end
            end
            LOAD: begin
                load_c  = 1'b1;
                round_d = 4'd1;
                rcon_d  = 8'h01;
                j_d     = 2'd0;
                state_d = SUB_REQ;
            end
            SUB_REQ: state_d = SUB_WAIT;
            SUB_WAIT: begin
                if (sub_ack) begin
                    wr_en_c   = 1'b1;
                    wr_data_c = back4_word_c ^ sub_out ^ {rcon_q, 24'h0};
                    j_d       = 2'd1;
                    state_d   = WORDS;
                end
            end
            WORDS: begin
                wr_en_c   = 1'b1;
                wr_data_c = back4_word_c ^ back1_word_c;
                if (j_q == 2'd3) begin
                    j_d = 2'd0;
                    if (round_q == LAST_ROUND) begin
                        state_d = FIN;
                    end else begin
                        round_d = round_q + 4'd1;
                        rcon_d  = xtime(rcon_q);
                        state_d = SUB_REQ;
                    end
                end else begin
                    j_d = j_q + 2'd1;
                end
            end
            FIN: begin
                kv_d    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Zeroize overrides everything, including a start seen in the same cycle.
        if (zeroize_c) begin
            state_d  = IDLE;
            round_d  = 4'd0;
            rcon_d   = 8'h01;
            j_d      = 2'd0;
            kv_d     = 1'b0;
            accept_c = 1'b0;
            load_c   = 1'b0;
            wr_en_c  = 1'b0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            round_q <= 4'd0;
            rcon_q  <= 8'h01;
            j_q     <= 2'd0;
            kv_q    <= 1'b0;
            key_q   <= '0;
        end else begin
            state_q <= state_d;
            round_q <= round_d;
            rcon_q  <= rcon_d;
            j_q     <= j_d;
            kv_q    <= kv_d;
            if (zeroize_c) begin
                key_q <= '0;
            end else if (accept_c) begin
                key_q <= key_in;
            end
        end
    end

    // NOTE: the key store is reset on purpose: an all-zero store is the defined empty state, not stale key material.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_WORDS; i++) store_q[i] <= '0;
        end else if (zeroize_c) begin
            for (int i = 0; i < NUM_WORDS; i++) store_q[i] <= '0;
        end else if (load_c) begin
            store_q[0] <= key_q[127:96];
            store_q[1] <= key_q[95:64];
            store_q[2] <= key_q[63:32];
            store_q[3] <= key_q[31:0];
        end else if (wr_en_c) begin
            store_q[wr_addr_c] <= wr_data_c;
        end
    end

    assign rk_addr_c = {rk_idx, 2'b00};

    always_comb begin
        rk_d = '0;
        if (rk_idx <= LAST_ROUND) begin
            rk_d = {store_q[rk_addr_c],        store_q[rk_addr_c + 6'd1],
                    store_q[rk_addr_c + 6'd2], store_q[rk_addr_c + 6'd3]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rk_q <= '0;
        end else if (zeroize_c) begin
            rk_q <= '0;
        end else begin
            rk_q <= rk_d;
        end
    end

    assign busy      = (state_q != IDLE) && (state_q != FIN);
    assign done      = (state_q == FIN);
    assign key_valid = kv_q | done;
    assign rk_out    = rk_q;

endmodule

// File: tb/tb_key_expansion_128.sv
// Directed bench for key_expansion_128: FIPS-197 vectors, restart/reset behaviour and read port.
// Build with KEYEXP_ZEROIZE_EN defined to also exercise zeroize.
module tb_key_expansion_128;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [127:0] key_in;
    logic         busy, done, key_valid;
    logic [3:0]   rk_idx;
    logic [127:0] rk_out;
`ifdef KEYEXP_ZEROIZE_EN
    logic         zeroize;
`endif

    always #5 clk = ~clk;

    key_expansion_128 dut (
        .clk       (clk),
        .rst_n     (rst_n),
`ifdef KEYEXP_ZEROIZE_EN
        .zeroize   (zeroize),
`endif
        .start     (start),
        .key_in    (key_in),
        .busy      (busy),
        .done      (done),
        .key_valid (key_valid),
        .rk_idx    (rk_idx),
        .rk_out    (rk_out)
    );

    localparam logic [127:0] KEY_A1   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] KEY_ALT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] ZK_RK1   = 128'h62636363626363636263636362636363;
    localparam logic [127:0] ZK_RK10  = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

    logic [127:0] a1_rk [11] = '{
        128'h2b7e151628aed2a6abf7158809cf4f3c,
        128'ha0fafe1788542cb123a339392a6c7605,
        128'hf2c295f27a96b9435935807a7359f67f,
        128'h3d80477d4716fe3e1e237e446d7a883b,
        128'hef44a541a8525b7fb671253bdb0bad00,
        128'hd4d1c6f87c839d87caf2b8bc11f915bc,
        128'h6d88a37a110b3efddbf98641ca0093fd,
        128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
        128'head27321b58dbad2312bf5607f8d292f,
        128'hac7766f319fadc2128d12941575c006e,
        128'hd014f9a8c9ee2589e13f0cc8b6630ca6
    };

    typedef struct {
        string        tag;
        logic [127:0] exp;
    } sb_t;

    sb_t sb_q[$];
    int  n_cmp = 0;
    int  n_err = 0;
    int  done_cyc, done_cnt;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Drive a new rk_idx, then compare the value registered from the previous index.
    task automatic sb_step(input logic [3:0] idx, input logic [127:0] exp, input string tag);
        sb_t e;
        @(negedge clk);
        rk_idx = idx;
        #1;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check(e.tag, rk_out, e.exp);
        end
        sb_q.push_back('{tag, exp});
    endtask

    task automatic sb_drain();
        sb_t e;
        while (sb_q.size() > 0) begin
            @(negedge clk);
            #1;
            e = sb_q.pop_front();
            check(e.tag, rk_out, e.exp);
        end
    endtask

    // Pulse start and watch 70 cycles; cycle 1 is the cycle after the accept edge.
    task automatic run_expansion(input logic [127:0] key, input bit inject,
                                 output int dcyc, output int dcnt);
        @(negedge clk);
        start  = 1'b1;
        key_in = key;
        dcyc   = 0;
        dcnt   = 0;
        for (int cyc = 1; cyc <= 70; cyc++) begin
            @(negedge clk);
            start = inject && (cyc == 20);
            if (inject && cyc == 20) key_in = KEY_ALT;
            if (cyc == 1) begin
                check("busy_after_start", 128'(busy), 128'd1);
                check("kv_drop_after_start", 128'(key_valid), 128'd0);
            end
            if (done) begin
                dcnt++;
                if (dcyc == 0) dcyc = cyc;
            end
        end
        start = 1'b0;
    endtask

    initial begin
        rst_n  = 1'b0;
        start  = 1'b0;
        key_in = '0;
        rk_idx = 4'd0;
`ifdef KEYEXP_ZEROIZE_EN
        zeroize = 1'b0;
`endif
        repeat (2) @(negedge clk);
        check("rst_busy", 128'(busy), 128'd0);
        check("rst_done", 128'(done), 128'd0);
        check("rst_kv", 128'(key_valid), 128'd0);
        check("rst_rk_out", rk_out, 128'd0);
        rst_n = 1'b1;

        sb_step(4'd0, 128'd0, "rst_store_rk0");
        sb_step(4'd10, 128'd0, "rst_store_rk10");
        sb_drain();

        // FIPS-197 A.1 with a second start injected mid-run.
        run_expansion(KEY_A1, 1'b1, done_cyc, done_cnt);
        check("a1_done_cycle", 128'(done_cyc), 128'd52);
        check("a1_done_count", 128'(done_cnt), 128'd1);
        check("a1_key_valid", 128'(key_valid), 128'd1);
        check("a1_busy_idle", 128'(busy), 128'd0);
        for (int i = 0; i < 16; i++) begin
            sb_step(4'(i), (i <= 10) ? a1_rk[i] : 128'd0, $sformatf("a1_rk%0d", i));
        end
        sb_drain();

        // All-zero key.
        run_expansion(128'd0, 1'b0, done_cyc, done_cnt);
        check("zk_done_cycle", 128'(done_cyc), 128'd52);
        sb_step(4'd0, 128'd0, "zk_rk0");
        sb_step(4'd1, ZK_RK1, "zk_rk1");
        sb_step(4'd10, ZK_RK10, "zk_rk10");
        sb_drain();

        // Reset asserted at cycle 30 of an A.1 expansion.
        rk_idx = 4'd0;
        @(negedge clk);
        start  = 1'b1;
        key_in = KEY_A1;
        for (int cyc = 1; cyc <= 30; cyc++) begin
            @(negedge clk);
            start = 1'b0;
        end
        rst_n = 1'b0;
        #1;
        check("midrst_busy", 128'(busy), 128'd0);
        check("midrst_done", 128'(done), 128'd0);
        check("midrst_kv", 128'(key_valid), 128'd0);
        check("midrst_rk_out", rk_out, 128'd0);
        @(negedge clk);
        rst_n = 1'b1;
        sb_step(4'd0, 128'd0, "midrst_store_rk0");
        sb_step(4'd1, 128'd0, "midrst_store_rk1");
        sb_drain();
        run_expansion(KEY_A1, 1'b0, done_cyc, done_cnt);
        check("rerun_done_cycle", 128'(done_cyc), 128'd52);
        sb_step(4'd0, a1_rk[0], "rerun_rk0");
        sb_step(4'd1, a1_rk[1], "rerun_rk1");
        sb_step(4'd5, a1_rk[5], "rerun_rk5");
        sb_step(4'd10, a1_rk[10], "rerun_rk10");
        sb_drain();

`ifdef KEYEXP_ZEROIZE_EN
        // Zeroize together with start at cycle 25.
        @(negedge clk);
        start  = 1'b1;
        key_in = KEY_A1;
        for (int cyc = 1; cyc <= 25; cyc++) begin
            @(negedge clk);
            start = 1'b0;
        end
        zeroize = 1'b1;
        start   = 1'b1;
        @(negedge clk);
        zeroize = 1'b0;
        start   = 1'b0;
        check("zer_busy", 128'(busy), 128'd0);
        check("zer_kv", 128'(key_valid), 128'd0);
        check("zer_rk_out", rk_out, 128'd0);
        repeat (3) @(negedge clk);
        check("zer_stays_idle", 128'(busy), 128'd0);
        for (int i = 0; i < 11; i++) sb_step(4'(i), 128'd0, $sformatf("zer_rk%0d", i));
        sb_drain();

        // Zeroize after a completed expansion.
        run_expansion(KEY_A1, 1'b0, done_cyc, done_cnt);
        sb_step(4'd1, a1_rk[1], "prezer_rk1");
        sb_drain();
        zeroize = 1'b1;
        @(negedge clk);
        zeroize = 1'b0;
        check("postdone_zer_kv", 128'(key_valid), 128'd0);
        check("postdone_zer_rk_out", rk_out, 128'd0);
        for (int i = 0; i < 16; i++) sb_step(4'(i), 128'd0, $sformatf("postzer_rk%0d", i));
        sb_drain();
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
